// File: rtl/ram_param.sv
// Parametrised single-clock RAM with separate write/read ports, write-first
// same-address bypass, 1- or 2-cycle read latency and a word-by-word clear engine.
module ram_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              clr_req,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
      $error("ram_param: READ_LAT must be 1 or 2");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  // Handshake: wr_en/rd_en are single-cycle strobes accepted only in IDLE with
  // no clr_req pending; out_valid is a one-cycle pulse qualifying out.
  logic              access_ok;
  logic              do_wr;
  logic              do_rd;
  logic              clr_wr;
  logic [DATA_W-1:0] rd_data;

  assign access_ok = !rst && (state == IDLE) && !clr_req;
  assign do_wr     = access_ok && wr_en;
  assign do_rd     = access_ok && rd_en;
  assign clr_wr    = !rst && (state == CLEAR);
  assign rd_data   = (do_wr && (wr_addr == rd_addr)) ? din : mem[rd_addr];

  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_ptr] <= '0;
    end else if (do_wr) begin
      mem[wr_addr] <= din;
    end
  end

  // busy mirrors state == CLEAR; the last clear word is where clr_ptr is all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_ptr <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

  generate
    if (READ_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          out       <= '0;
          out_valid <= 1'b0;
        end else begin
          out_valid <= do_rd;
          if (do_rd) out <= rd_data;
        end
      end
    end else begin : g_lat2
      logic [DATA_W-1:0] s1_data;
      logic              s1_valid;

      // The pipeline keeps draining during a clear; only rst flushes it.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_data   <= '0;
          s1_valid  <= 1'b0;
          out       <= '0;
          out_valid <= 1'b0;
        end else begin
          s1_valid  <= do_rd;
          if (do_rd) s1_data <= rd_data;
          out_valid <= s1_valid;
          if (s1_valid) out <= s1_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_param.sv
// Bench for ram_param: one 8x16/latency-1 instance and one 16x8/latency-2 instance,
// exercised in turn against a transaction-level memory model.
module tb_ram_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] din;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        clr_req;

  logic [7:0]  out_a;
  logic        out_valid_a;
  logic        busy_a;
  logic [15:0] out_b;
  logic        out_valid_b;
  logic        busy_b;

  logic        rst_a;
  logic        rst_b;
  logic [15:0] obs_out;
  logic        obs_valid;
  logic        obs_busy;

  // clock/reset block: the unselected instance is held in reset
  always #5 clk = ~clk;
  assign rst_a = rst | sel;
  assign rst_b = rst | ~sel;

  ram_param #(.DATA_W(8), .ADDR_W(4), .READ_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .wr_en(wr_en), .wr_addr(wr_addr), .din(din[7:0]),
    .rd_en(rd_en), .rd_addr(rd_addr), .clr_req(clr_req),
    .out(out_a), .out_valid(out_valid_a), .busy(busy_a)
  );

  ram_param #(.DATA_W(16), .ADDR_W(3), .READ_LAT(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .din(din),
    .rd_en(rd_en), .rd_addr(rd_addr[2:0]), .clr_req(clr_req),
    .out(out_b), .out_valid(out_valid_b), .busy(busy_b)
  );

  assign obs_out   = sel ? out_b : {8'h00, out_a};
  assign obs_valid = sel ? out_valid_b : out_valid_a;
  assign obs_busy  = sel ? busy_b : busy_a;

  // reference model: whole-array memory, remaining clear cycles, read queue
  int          depth;
  int          lat;
  logic [15:0] dmask;
  logic [3:0]  amask;
  logic [15:0] m_mem [16];
  int          m_busy;
  logic [15:0] exp_q [$];
  int          rem_q [$];
  logic [15:0] m_out;
  logic        m_valid;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_busy  = depth;
      exp_q.delete();
      rem_q.delete();
      m_out   = '0;
      m_valid = 1'b0;
      foreach (m_mem[i]) m_mem[i] = '0;
      return;
    end
    if (m_busy > 0) begin
      m_busy--;
    end else if (clr_req) begin
      m_busy = depth;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      if (rd_en) begin
        exp_q.push_back((wr_en && wr_addr == rd_addr) ? din : m_mem[rd_addr]);
        rem_q.push_back(lat);
      end
      if (wr_en) m_mem[wr_addr] = din;
    end
    foreach (rem_q[i]) rem_q[i]--;
    m_valid = 1'b0;
    if (rem_q.size() > 0 && rem_q[0] == 0) begin
      void'(rem_q.pop_front());
      m_out   = exp_q.pop_front();
      m_valid = 1'b1;
    end
  endtask

  // driver: one clock of stimulus, then compare every output against the model
  task automatic step(input logic r, input logic we, input logic [3:0] wa,
                      input logic [15:0] wd, input logic re, input logic [3:0] ra,
                      input logic cr);
    rst     = r;
    wr_en   = we;
    wr_addr = wa & amask;
    din     = wd & dmask;
    rd_en   = re;
    rd_addr = ra & amask;
    clr_req = cr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("out", {16'h0, obs_out}, {16'h0, m_out});
    check("out_valid", {31'h0, obs_valid}, {31'h0, m_valid});
    check("busy", {31'h0, obs_busy}, {31'h0, m_busy > 0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic read_expect(input string tag, input logic [3:0] a, input logic [15:0] v);
    step(1'b0, 1'b0, 4'h0, 16'h0, 1'b1, a, 1'b0);
    idle(lat - 1);
    check(tag, {16'h0, obs_out}, {16'h0, v & dmask});
    check({tag, "_valid"}, {31'h0, obs_valid}, 32'h1);
    idle(1);
  endtask

  task automatic count_busy(input string tag);
    int cnt;
    cnt = obs_busy ? 1 : 0;
    for (int i = 0; i < depth + 3; i++) begin
      idle(1);
      if (obs_busy) cnt++;
    end
    check(tag, cnt, depth);
  endtask

  task automatic run_phase(input logic s);
    int vcnt;
    sel   = s;
    depth = s ? 8 : 16;
    lat   = s ? 2 : 1;
    dmask = s ? 16'hFFFF : 16'h00FF;
    amask = s ? 4'h7 : 4'hF;

    // reset then full clear
    step(1'b1, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0);
    check("reset_out", {16'h0, obs_out}, 32'h0);
    count_busy("busy_after_reset");
    for (int a = 0; a < depth; a++) step(1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 4'(a), 1'b0);
    idle(lat);

    // write then read
    step(1'b0, 1'b1, 4'h3, 16'h0093, 1'b0, 4'h0, 1'b0);
    read_expect("wr_rd", 4'h3, 16'h0093);

    // same-address bypass
    step(1'b0, 1'b1, 4'h5, 16'h0011, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h5, 16'h00A5, 1'b1, 4'h5, 1'b0);
    idle(lat - 1);
    check("bypass", {16'h0, obs_out}, 32'h00A5);
    read_expect("bypass_again", 4'h5, 16'h00A5);

    // accesses ignored while busy
    step(1'b0, 1'b1, 4'h7, 16'h003C, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b1);
    vcnt = 0;
    for (int i = 0; i < depth; i++) begin
      step(1'b0, 1'b1, 4'h7, 16'hFFFF, 1'b1, 4'h7, 1'b0);
      if (obs_valid) vcnt++;
    end
    check("valid_while_busy", vcnt, 0);
    check("busy_fell", {31'h0, obs_busy}, 32'h0);
    read_expect("cleared_7", 4'h7, 16'h0000);

    // clr_req wins over a same-cycle write
    step(1'b0, 1'b1, 4'h2, 16'h0055, 1'b0, 4'h0, 1'b1);
    idle(depth);
    read_expect("collision_2", 4'h2, 16'h0000);

    // reset mid-clear, then streaming reads
    step(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b1);
    idle(4);
    step(1'b1, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0);
    count_busy("busy_after_midclear_reset");
    for (int a = 0; a < depth; a++) step(1'b0, 1'b1, 4'(a), 16'(16'h1000 + a), 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < depth + lat; i++) begin
      step(1'b0, 1'b0, 4'h0, 16'h0, i < depth, 4'(i), 1'b0);
      if (i >= lat - 1 && i - lat + 1 < depth) begin
        check("stream_data", {16'h0, obs_out}, {16'h0, 16'(16'h1000 + i - lat + 1) & dmask});
        check("stream_valid", {31'h0, obs_valid}, 32'h1);
      end else begin
        check("stream_gap", {31'h0, obs_valid}, 32'h0);
      end
    end

    // randomized traffic with dense address collisions
    for (int i = 0; i < 400; i++) begin
      logic [3:0] wa;
      logic [3:0] ra;
      wa = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      step($urandom_range(0, 149) == 0, 1'($urandom_range(0, 1)), wa, 16'($urandom),
           1'($urandom_range(0, 1)), ra, $urandom_range(0, 49) == 0);
    end
    idle(lat + 1);
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; wr_en = 1'b0; wr_addr = '0; din = '0;
    rd_en = 1'b0; rd_addr = '0; clr_req = 1'b0;
    m_busy = 0; m_out = '0; m_valid = 1'b0;
    @(negedge clk);
    run_phase(1'b0);
    run_phase(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_param.md
Name: ram_param

Overview:
- Parametrised single-clock RAM; successor to the fixed 16x8 RAM.
- Separate write and read ports; configurable width, depth and read latency.
- Read-valid strobe, write-first same-address bypass, hardware clear engine that zeroes every word after reset or on request.
- Used as the general scratch/buffer memory for later lab datapaths.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 4, address width; depth is DEPTH = 2**ADDR_W, so no address is out of range.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2. Any other value is a synthesis-time error.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- din  in  DATA_W  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- clr_req  in  1  request to zero the whole array.
- out  out  DATA_W  read data.
- out_valid  out  1  one-cycle pulse; out holds read data for this cycle.
- busy  out  1  clear engine active; all accesses ignored while high.

Behaviour:
- Reset, sampled at a rising edge:
  - out = 0, out_valid = 0, read pipeline flushed.
  - FSM = CLEAR, clr_ptr = 0, busy = 1.
  - While rst stays high, FSM holds CLEAR with clr_ptr = 0.
- FSM states: IDLE, CLEAR.
- CLEAR:
  - Each cycle with rst low: mem[clr_ptr] <= 0, clr_ptr increments.
  - On the edge that writes clr_ptr = DEPTH-1: FSM goes to IDLE, busy = 0 from the next cycle.
  - busy is therefore high for exactly DEPTH cycles after rst deasserts.
  - wr_en, rd_en and clr_req are ignored (no write, no read launch).
- IDLE:
  - clr_req = 1 at an edge: FSM -> CLEAR, clr_ptr = 0, busy = 1 next cycle.
  - A wr_en or rd_en in that same cycle is dropped; clear wins.
- Write: in IDLE with wr_en = 1 and no clr_req, mem[wr_addr] <= din at the edge. Write latency is 1 cycle.
- Read timing:
  - Read launched in IDLE with rd_en = 1 and no clr_req.
  - READ_LAT=1: out and out_valid update at the sampling edge, visible the following cycle.
  - READ_LAT=2: one extra register stage, so out and out_valid are visible two cycles after the rd_en cycle.
- Back-to-back reads: rd_en high every cycle gives out_valid high every cycle, in issue order, with no bubbles.
- Read already in the pipeline when a clear starts: completes normally with pre-clear data. Only rst flushes the pipeline.
- Same-cycle read and write:
  - Same address: write-first; returned data equals din.
  - Different addresses: independent.
- Hold behaviour: out holds its last value when no read completes; out_valid is 0 in those cycles.
- Reset mid-clear: clear restarts from address 0 and the full DEPTH-cycle sequence is repeated.
- No arithmetic beyond the clr_ptr increment. clr_ptr is ADDR_W+1 bits or compared against DEPTH-1; it must never wrap back into IDLE early.

Test Plan:
- Reset and clear (defaults):
  - Stimulus: rst high 2 cycles, then low.
  - Required: busy=1 for exactly 16 cycles, out=0, out_valid=0 throughout; then reading addresses 0..15 returns 8'h00 each with out_valid pulses.
- Write and read:
  - Stimulus: in IDLE write 8'h93 to address 3, then rd_en at address 3.
  - Required: out=8'h93 with out_valid=1 one cycle after rd_en (READ_LAT=1); with READ_LAT=2, two cycles after.
- Bypass:
  - Stimulus: same cycle wr_en at address 5 with din=8'hA5 and rd_en at address 5, where address 5 previously held 8'h11.
  - Required: out=8'hA5.
  - Next cycle, rd_en at address 5: out=8'hA5 again.
- Accesses ignored while busy:
  - Stimulus: write 8'h3C to address 7; pulse clr_req; during busy, issue wr_en at address 7 with 8'hFF and rd_en at address 7.
  - Required: no out_valid while busy; after busy falls, reading address 7 returns 8'h00.
- clr_req collision:
  - Stimulus: clr_req and wr_en (address 2, 8'h55) in the same cycle.
  - Required: write dropped; address 2 reads 8'h00 after the clear.
- Reset mid-clear and streaming (READ_LAT=2, DATA_W=16, ADDR_W=3):
  - Stimulus: assert rst at clear step 4.
  - Required: busy stays high 8 further cycles after release.
  - Then 8 back-to-back reads of data previously written as 16'h1000+addr return in order, out_valid high for 8 consecutive cycles starting 2 cycles after the first rd_en.
